// File: rtl/dht11_sched.sv
// DHT11 read scheduler: power-up delay, periodic start pulses, checksum check, retry with backoff,
// display selection. Define DHT11_MANUAL_TRIG_EN to add the trig input (IDLE -> START on demand).
module dht11_sched #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned POWERUP_MS = 1000,
    parameter int unsigned PERIOD_MS  = 2000,
    parameter int unsigned TIMEOUT_MS = 10,
    parameter int unsigned RETRY_MS   = 1000,
    parameter int unsigned MAX_RETRY  = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key,
`ifdef DHT11_MANUAL_TRIG_EN
    input  logic        trig,
`endif
    input  logic        rd_done,
    input  logic [39:0] rd_frame,
    output logic        start,
    output logic [15:0] disp_data,
    output logic        sign,
    output logic        disp_sel,
    output logic        valid,
    output logic        fail,
    output logic [7:0]  err_cnt
);

    // 64-bit math so large CLK_FREQ * ms products cannot overflow; zero-length waits become one cycle.
    function automatic longint unsigned ms_to_cycles(input longint unsigned ms);
        longint unsigned c;
        c = (ms * 64'(CLK_FREQ)) / 64'd1000;
        return (c == 64'd0) ? 64'd1 : c;
    endfunction

    localparam longint unsigned PWR_N  = ms_to_cycles(64'(POWERUP_MS));
    localparam longint unsigned IDLE_N = ms_to_cycles(64'(PERIOD_MS));
    localparam longint unsigned TMO_N  = ms_to_cycles(64'(TIMEOUT_MS));
    localparam longint unsigned RTY_N  = ms_to_cycles(64'(RETRY_MS));
    localparam longint unsigned MAX_A  = (PWR_N > IDLE_N) ? PWR_N : IDLE_N;
    localparam longint unsigned MAX_B  = (TMO_N > RTY_N) ? TMO_N : RTY_N;
    localparam longint unsigned MAX_N  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = (MAX_N < 2) ? 1 : $clog2(MAX_N);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_N - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_N - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_N - 1);
    localparam logic [CNT_W-1:0] RTY_LAST  = CNT_W'(RTY_N - 1);
    localparam logic [RTY_W-1:0] MAX_R     = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {PWRUP, IDLE, START, WAIT, CHECK, BACKOFF} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [RTY_W-1:0]   retry_reg;
    logic [39:0]        frame_reg;
    logic [15:0]        hum_reg;
    logic [15:0]        tmp_reg;
    logic               start_reg;
    logic               valid_reg;
    logic               fail_reg;
    logic [7:0]         err_reg;
    logic               sel_reg;

    logic [7:0]         sum;
    logic               sum_ok;
    logic               tmo_hit;
    logic               bad_attempt;

    // A rd_done in the expiry cycle suppresses the timeout.
    always_comb begin
        sum         = frame_reg[39:32] + frame_reg[31:24] + frame_reg[23:16] + frame_reg[15:8];
        sum_ok      = (sum == frame_reg[7:0]);
        tmo_hit     = (state_reg == WAIT) && !rd_done && (cnt_reg == TMO_LAST);
        bad_attempt = tmo_hit || ((state_reg == CHECK) && !sum_ok);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg <= PWRUP;
            cnt_reg   <= '0;
            retry_reg <= '0;
            frame_reg <= '0;
            hum_reg   <= '0;
            tmp_reg   <= '0;
            start_reg <= 1'b0;
            valid_reg <= 1'b0;
            fail_reg  <= 1'b0;
            err_reg   <= '0;
        end else begin
            start_reg <= 1'b0;
            case (state_reg)
                PWRUP: begin
                    if (cnt_reg == PWR_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= START;
                        start_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                IDLE: begin
`ifdef DHT11_MANUAL_TRIG_EN
                    if (trig || (cnt_reg == IDLE_LAST)) begin
`else
                    if (cnt_reg == IDLE_LAST) begin
`endif
                        cnt_reg   <= '0;
                        state_reg <= START;
                        start_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                START: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (rd_done) begin
                        frame_reg <= rd_frame;
                        state_reg <= CHECK;
                    end else if (!tmo_hit) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                CHECK: begin
                    if (sum_ok) begin
                        hum_reg   <= frame_reg[39:24];
                        tmp_reg   <= frame_reg[23:8];
                        valid_reg <= 1'b1;
                        fail_reg  <= 1'b0;
                        retry_reg <= '0;
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                BACKOFF: begin
                    if (cnt_reg == RTY_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= START;
                        start_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= PWRUP;
                end
            endcase

            // Timeouts and checksum errors share one retry/fail path.
            if (bad_attempt) begin
                if (err_reg != 8'hFF) begin
                    err_reg <= err_reg + 8'd1;
                end
                cnt_reg <= '0;
                if (retry_reg < MAX_R) begin
                    retry_reg <= retry_reg + RTY_W'(1);
                    state_reg <= BACKOFF;
                end else begin
                    fail_reg  <= 1'b1;
                    retry_reg <= '0;
                    state_reg <= IDLE;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sel_reg <= 1'b0;
        end else if (key) begin
            sel_reg <= ~sel_reg;
        end
    end

    always_comb begin
        if (sel_reg) begin
            disp_data = {tmp_reg[15:8], 1'b0, tmp_reg[6:0]};
            sign      = tmp_reg[7];
        end else begin
            disp_data = hum_reg;
            sign      = 1'b0;
        end
    end

    assign start    = start_reg;
    assign disp_sel = sel_reg;
    assign valid    = valid_reg;
    assign fail     = fail_reg;
    assign err_cnt  = err_reg;

endmodule

// File: tb/tb_dht11_sched.sv
// Bench for dht11_sched at 1 ms = 1 cycle: timing of start pulses, frame acceptance, retries,
// display select; a small model predicts stored values, flags and start-to-start gaps.
module tb_dht11_sched;

    localparam int P_PWR  = 5;
    localparam int P_PER  = 20;
    localparam int P_TMO  = 4;
    localparam int P_RTY  = 3;
    localparam int P_MAXR = 2;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        key = 1'b0;
    logic        rd_done = 1'b0;
    logic [39:0] rd_frame = '0;
`ifdef DHT11_MANUAL_TRIG_EN
    logic        trig = 1'b0;
`endif
    logic        start;
    logic [15:0] disp_data;
    logic        sign;
    logic        disp_sel;
    logic        valid;
    logic        fail;
    logic [7:0]  err_cnt;

    logic [27:0] obs;
    assign obs = {disp_data, sign, disp_sel, valid, fail, err_cnt};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] m_hum;
    logic [15:0] m_tmp;
    bit          m_valid;
    bit          m_fail;
    bit          m_sel;
    int          m_err;
    int          m_retries;

    always #5 clk = ~clk;

    dht11_sched #(
        .CLK_FREQ(1000), .POWERUP_MS(P_PWR), .PERIOD_MS(P_PER),
        .TIMEOUT_MS(P_TMO), .RETRY_MS(P_RTY), .MAX_RETRY(P_MAXR)
    ) dut (
        .sys_clk(clk), .sys_rst_n(sys_rst_n), .key(key),
`ifdef DHT11_MANUAL_TRIG_EN
        .trig(trig),
`endif
        .rd_done(rd_done), .rd_frame(rd_frame), .start(start),
        .disp_data(disp_data), .sign(sign), .disp_sel(disp_sel),
        .valid(valid), .fail(fail), .err_cnt(err_cnt)
    );

    function automatic void model_reset();
        m_hum = '0; m_tmp = '0; m_valid = 0; m_fail = 0; m_sel = 0; m_err = 0; m_retries = 0;
    endfunction

    function automatic logic [27:0] exp_status();
        logic [15:0] d;
        logic        s;
        if (m_sel) begin
            d = {m_tmp[15:8], 1'b0, m_tmp[6:0]};
            s = m_tmp[7];
        end else begin
            d = m_hum;
            s = 1'b0;
        end
        return {d, s, m_sel, m_valid, m_fail, 8'(m_err)};
    endfunction

    // Applies one attempt to the model and returns the number of cycles until the next start
    // pulse, counted from the cycle two after rd_done (frames) or from the expiry cycle (timeouts).
    function automatic int model_attempt(input bit got, input logic [39:0] f);
        int s;
        s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
        if (got && s == int'(f[7:0])) begin
            m_hum = f[39:24]; m_tmp = f[23:8];
            m_valid = 1; m_fail = 0; m_retries = 0;
            return P_PER;
        end
        if (m_err < 255) m_err++;
        if (m_retries < P_MAXR) begin
            m_retries++;
            return got ? P_RTY : P_RTY + 1;
        end
        m_fail = 1; m_retries = 0;
        return got ? P_PER : P_PER + 1;
    endfunction

    function automatic logic [39:0] rand_frame(input bit good);
        logic [31:0] d;
        logic [7:0]  c;
        d = $urandom;
        c = 8'((int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0])) % 256);
        if (!good) c = c ^ 8'($urandom_range(1, 255));
        return {d, c};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press_key();
        key = 1'b1;
        m_sel = !m_sel;
        tick();
        key = 1'b0;
    endtask

    // Counts cycles to the next start pulse; optional noise = key pulses and ignored rd_done.
    task automatic wait_start(input bit noise, output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            key = 1'b0;
            rd_done = 1'b0;
            if (start === 1'b1) begin
                n = i;
                break;
            end
            if (noise) begin
                if ($urandom_range(0, 7) == 0) begin
                    key = 1'b1;
                    m_sel = !m_sel;
                end
                if ($urandom_range(0, 5) == 0) begin
                    rd_frame = rand_frame(1'b1);
                    rd_done = 1'b1;
                end
            end
        end
    endtask

    // Called in the START cycle; rd_done lands in the d-th WAIT cycle; returns in the CHECK cycle.
    task automatic send_frame(input int d, input logic [39:0] f);
        repeat (d) tick();
        rd_frame = f;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (obs !== 28'd0 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: status=%h start=%b, required status=0 start=0", obs, start);
        end
        sys_rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= P_PWR; i++) begin
            tick();
            n_checks++;
            if (start !== (i == P_PWR) || obs !== exp_status()) begin
                n_fail++;
                $display("FAIL pwrup_cycle%0d: start=%b status=%h, required start=%b status=%h",
                         i, start, obs, (i == P_PWR), exp_status());
            end
        end
        $display("txn reset: first start after %0d cycles", P_PWR);
    endtask

    task automatic test_good_frame();
        logic [39:0] f;
        int gap, n;
        f = 40'h46_00_18_1A_78;
        send_frame(2, f);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL good_early: valid=%b one cycle after rd_done, required 0", valid);
        end
        tick();
        gap = model_attempt(1'b1, f);
        n_checks++;
        if (obs !== exp_status() || disp_data !== 16'h4600 || sign !== 1'b0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL good_frame: status=%h, required %h (disp 4600 valid 1)", obs, exp_status());
        end
        press_key();
        n_checks++;
        if (disp_sel !== 1'b1 || disp_data !== 16'h181A || sign !== 1'b0) begin
            n_fail++;
            $display("FAIL key_toggle: sel=%b disp=%h sign=%b, required sel=1 disp=181a sign=0",
                     disp_sel, disp_data, sign);
        end
        wait_start(1'b1, n);
        n_checks++;
        if (n !== gap - 1) begin
            n_fail++;
            $display("FAIL good_period: next start after %0d cycles, required %0d", n, gap - 1);
        end
        $display("txn good frame %h: gap=%0d", f, n);
    endtask

    task automatic test_bad_checksum();
        logic [39:0] f;
        int gap, n;
        f = 40'h46_00_18_1A_77;
        for (int i = 0; i < 3; i++) begin
            send_frame(1, f);
            tick();
            gap = model_attempt(1'b1, f);
            n_checks++;
            if (obs !== exp_status()) begin
                n_fail++;
                $display("FAIL bad_status%0d: status=%h, required %h", i, obs, exp_status());
            end
            wait_start(1'b1, n);
            n_checks++;
            if (n !== gap) begin
                n_fail++;
                $display("FAIL bad_gap%0d: next start after %0d cycles, required %0d", i, n, gap);
            end
            $display("txn bad checksum %0d: gap=%0d err_cnt=%0d fail=%b", i, n, err_cnt, fail);
        end
        n_checks++;
        if (fail !== 1'b1 || err_cnt !== 8'd3 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL retries_exhausted: fail=%b err=%0d valid=%b, required fail=1 err=3 valid=1",
                     fail, err_cnt, valid);
        end
    endtask

    task automatic test_timeout();
        logic [39:0] f;
        int gap, n;
        repeat (P_TMO) tick();
        gap = model_attempt(1'b0, '0);
        wait_start(1'b1, n);
        n_checks++;
        if (n !== gap) begin
            n_fail++;
            $display("FAIL timeout_gap: retry start after %0d cycles, required %0d", n, gap);
        end
        n_checks++;
        if (obs !== exp_status()) begin
            n_fail++;
            $display("FAIL timeout_status: status=%h, required %h", obs, exp_status());
        end
        $display("txn timeout: gap=%0d err_cnt=%0d", n, err_cnt);
        f = rand_frame(1'b1);
        send_frame(P_TMO, f);
        tick();
        gap = model_attempt(1'b1, f);
        n_checks++;
        if (obs !== exp_status() || err_cnt !== 8'd4 || fail !== 1'b0) begin
            n_fail++;
            $display("FAIL expiry_tie: status=%h, required %h (err 4, fail 0)", obs, exp_status());
        end
        wait_start(1'b1, n);
        n_checks++;
        if (n !== gap) begin
            n_fail++;
            $display("FAIL expiry_tie_gap: next start after %0d cycles, required %0d", n, gap);
        end
        $display("txn frame at expiry %h: gap=%0d", f, n);
    endtask

    task automatic test_negative_temp();
        logic [39:0] f;
        int gap, n, used;
        f = 40'h46_00_02_85_CD;
        used = 0;
        send_frame(int'($urandom_range(1, P_TMO)), f);
        tick();
        gap = model_attempt(1'b1, f);
        if (!m_sel) begin
            press_key();
            used++;
        end
        n_checks++;
        if (disp_sel !== 1'b1 || disp_data !== 16'h0205 || sign !== 1'b1 || obs !== exp_status()) begin
            n_fail++;
            $display("FAIL neg_temp: sel=%b disp=%h sign=%b, required sel=1 disp=0205 sign=1",
                     disp_sel, disp_data, sign);
        end
        press_key();
        used++;
        n_checks++;
        if (disp_data !== 16'h4600 || sign !== 1'b0 || obs !== exp_status()) begin
            n_fail++;
            $display("FAIL neg_hum_sign: disp=%h sign=%b, required disp=4600 sign=0", disp_data, sign);
        end
        wait_start(1'b1, n);
        n_checks++;
        if (n !== gap - used) begin
            n_fail++;
            $display("FAIL neg_gap: next start after %0d cycles, required %0d", n, gap - used);
        end
        $display("txn negative temp %h: gap=%0d", f, n);
    endtask

    task automatic test_back_to_back();
        logic [39:0] f;
        int gap, n, kind, d;
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                repeat (P_TMO) tick();
                gap = model_attempt(1'b0, '0);
                wait_start(1'b1, n);
                n_checks++;
                if (n !== gap || obs !== exp_status()) begin
                    n_fail++;
                    $display("FAIL rnd%0d_timeout: gap=%0d status=%h, required gap=%0d status=%h",
                             t, n, obs, gap, exp_status());
                end
                $display("txn rnd%0d timeout: gap=%0d err_cnt=%0d fail=%b", t, n, err_cnt, fail);
            end else begin
                f = rand_frame(kind != 1);
                d = int'($urandom_range(1, P_TMO));
                send_frame(d, f);
                tick();
                gap = model_attempt(1'b1, f);
                n_checks++;
                if (obs !== exp_status()) begin
                    n_fail++;
                    $display("FAIL rnd%0d_status: status=%h, required %h", t, obs, exp_status());
                end
                wait_start(1'b1, n);
                n_checks++;
                if (n !== gap) begin
                    n_fail++;
                    $display("FAIL rnd%0d_gap: next start after %0d cycles, required %0d", t, n, gap);
                end
                $display("txn rnd%0d frame %h delay=%0d: gap=%0d err_cnt=%0d", t, f, d, n, err_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        tick();
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        model_reset();
        rd_frame = rand_frame(1'b1);
        rd_done = 1'b1;
        n_checks++;
        if (start !== 1'b0 || obs !== exp_status()) begin
            n_fail++;
            $display("FAIL mid_reset: start=%b status=%h, required start=0 status=%h", start, obs, exp_status());
        end
        wait_start(1'b0, n);
        n_checks++;
        if (n !== P_PWR || obs !== exp_status()) begin
            n_fail++;
            $display("FAIL mid_reset_restart: gap=%0d status=%h, required gap=%0d status=%h",
                     n, obs, P_PWR, exp_status());
        end
        $display("txn reset during wait: restart gap=%0d", n);
    endtask

`ifdef DHT11_MANUAL_TRIG_EN
    task automatic test_manual_trig();
        logic [39:0] f;
        int gap;
        f = rand_frame(1'b1);
        send_frame(1, f);
        tick();
        gap = model_attempt(1'b1, f);
        repeat (3) tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        n_checks++;
        if (start !== 1'b1 || obs !== exp_status()) begin
            n_fail++;
            $display("FAIL manual_trig: start=%b status=%h, required start=1 status=%h (period %0d)",
                     start, obs, exp_status(), gap);
        end
        $display("txn manual trig: start=%b", start);
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_timeout();
        test_negative_temp();
        test_back_to_back();
        test_reset_mid();
`ifdef DHT11_MANUAL_TRIG_EN
        test_manual_trig();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dht11_sched.md
DHT11_SCHED -- requirements
Module: dht11_sched

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning sys_clk frequency in Hz.
REQ-002 SHALL have parameter POWERUP_MS, default 1000, meaning the wait after reset before the first read.
REQ-003 SHALL have parameter PERIOD_MS, default 2000, meaning the idle time from entering IDLE to the next start.
REQ-004 SHALL have parameter TIMEOUT_MS, default 10, meaning the maximum wait for rd_done after start.
REQ-005 SHALL have parameter RETRY_MS, default 1000, meaning the backoff before a retry.
REQ-006 SHALL have parameter MAX_RETRY, default 2, meaning the retries allowed per measurement.
REQ-007 SHALL have port sys_clk, input, 1 bit: the single clock.
REQ-008 SHALL have port sys_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-009 SHALL have port key, input, 1 bit: debounced one-cycle pulse that toggles display selection.
REQ-010 SHALL have port rd_done, input, 1 bit: one-cycle pulse from the DHT11 bus engine marking rd_frame valid.
REQ-011 SHALL have port rd_frame, input, 40 bits: {hum_int, hum_dec, tmp_int, tmp_dec, checksum}, MSB first.
REQ-012 SHALL have port start, output, 1 bit: one-cycle pulse that launches a bus transaction.
REQ-013 SHALL have port disp_data, output, 16 bits: {int, dec} of the selected quantity; for temperature, dec has bit 7 masked.
REQ-014 SHALL have port sign, output, 1 bit: 1 when temperature is negative (tmp_dec bit 7); always 0 when humidity is selected.
REQ-015 SHALL have port disp_sel, output, 1 bit: 0 selects humidity, 1 selects temperature.
REQ-016 SHALL have port valid, output, 1 bit: high once at least one good frame has been latched.
REQ-017 SHALL have port fail, output, 1 bit: sticky high after retries are exhausted; cleared by the next good frame.
REQ-018 SHALL have port err_cnt, output, 8 bits: count of bad or timed-out attempts, saturating at 255.

Function
REQ-019 SHALL implement the states PWRUP, IDLE, START, WAIT, CHECK, BACKOFF.
REQ-020 PWRUP SHALL count POWERUP_MS*CLK_FREQ/1000 cycles, then go to START.
REQ-021 IDLE SHALL count PERIOD_MS cycles (same ms conversion), then go to START.
REQ-022 START SHALL last exactly one cycle, drive start=1, clear the timeout counter, and go to WAIT; start SHALL be 0 in every other state.
REQ-023 WAIT: on rd_done=1 SHALL go to CHECK and latch rd_frame; after TIMEOUT_MS without rd_done SHALL treat the attempt as bad.
REQ-024 If rd_done and timeout expiry coincide, rd_done SHALL win.
REQ-025 CHECK SHALL compute (hum_int+hum_dec+tmp_int+tmp_dec) mod 256 and compare it with checksum.
REQ-026 A good frame SHALL update the stored values, set valid=1, clear fail, reset the retry count, and go to IDLE.
REQ-027 After a good frame, disp_data/sign SHALL reflect the new values 2 cycles after the cycle rd_done is sampled.
REQ-028 A bad attempt (checksum mismatch or timeout) SHALL increment err_cnt (saturating) and leave stored values unchanged.
REQ-029 After a bad attempt: if retries < MAX_RETRY, SHALL increment retries and go to BACKOFF.
REQ-030 After a bad attempt: otherwise SHALL set fail=1, clear retries, and go to IDLE.
REQ-031 BACKOFF SHALL wait RETRY_MS, then go to START.
REQ-032 rd_done outside WAIT SHALL be ignored.
REQ-033 key SHALL toggle disp_sel on the following cycle in any state, independent of the FSM.
REQ-034 disp_data/sign SHALL be a combinational select from registered stored values, so they change the cycle after disp_sel changes.
REQ-035 All counters SHALL be wide enough for the largest parameterised count without wrap.

Reset
REQ-036 On sys_rst_n=0 at a clock edge: state=PWRUP, all counters=0, start=0, disp_data=0, sign=0, disp_sel=0, valid=0, fail=0, err_cnt=0, stored frame=0.
REQ-037 Reset asserted mid-transaction SHALL abort it with no start pulse; a late rd_done after reset SHALL be ignored (state is PWRUP).

Configuration
REQ-038 With macro DHT11_MANUAL_TRIG_EN defined, input trig (1 bit, one-cycle pulse) SHALL exist; trig in IDLE SHALL go to START on the next cycle.
REQ-039 With DHT11_MANUAL_TRIG_EN defined, trig in any other state SHALL be ignored.
REQ-040 Without DHT11_MANUAL_TRIG_EN, the trig port and its logic SHALL be absent, and behaviour SHALL be purely periodic.

Verification (CLK_FREQ=1000 so 1 ms = 1 cycle; POWERUP_MS=5, PERIOD_MS=20, TIMEOUT_MS=4, RETRY_MS=3, MAX_RETRY=2)
REQ-041 Reset release -> first start pulse at cycle 5 after PWRUP entry; outputs stay at reset values until then.
REQ-042 rd_frame=0x46_00_18_1A_78 with rd_done at WAIT -> valid=1, disp_data=0x4600, sign=0 two cycles later; after a key pulse -> disp_sel=1, disp_data=0x181A.
REQ-043 Frame 0x46_00_18_1A_77, repeated 3 times -> 2 retries spaced by 3-cycle backoff, err_cnt=3, fail=1, then IDLE with the prior values kept.
REQ-044 No rd_done -> timeout 4 cycles after start, then retry start 3 cycles later; rd_done arriving in the same cycle as expiry -> frame accepted, err_cnt unchanged.
REQ-045 Frame 0x46_00_02_85_CD, temperature selected -> sign=1, disp_data=0x0205.
REQ-046 Reset pulse during WAIT followed by a rd_done pulse -> frame ignored, PWRUP restarts; with DHT11_MANUAL_TRIG_EN, trig in IDLE -> start on the next cycle.
